// File: rtl/seg_display_scanner_pkg.sv
// Shared constants for the 7-segment scanning path: blank/off codes and the
// active-low gfedcba hex glyph table.
package seg_display_scanner_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] digit_t;
  typedef logic [2:0] slot_t;

  localparam slot_t      LAST_SLOT = 3'd5;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [5:0] AN_OFF    = 6'h3F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex code to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decoder
  import seg_display_scanner_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_HEX[code];
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Six-digit common-anode scanner with a double-buffered digit store, per-slot
// ghost blanking and optional leading-zero suppression.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int              CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  slot_t         slot_q, slot_d;
  logic          pend_valid_q, pend_valid_d;
  digit_t        pend_q [NUM_DIGITS];
  digit_t        pend_d [NUM_DIGITS];
  digit_t        act_q  [NUM_DIGITS];
  digit_t        act_d  [NUM_DIGITS];
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [5:0] lz_mask;
  logic       all_zero;
  logic [6:0] dec_seg;

  assign tick = (div_cnt_q == DIV_LAST);
  assign wrap = tick && (slot_q == LAST_SLOT);

  seg7_hex_decoder u_dec (
    .code  (act_q[slot_q]),
    .seg_n (dec_seg)
  );

  // lz_mask[k] is set when every digit from d1 up to slot k is zero; d6 never masked.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS - 1; k++) begin
      all_zero   = all_zero && (act_q[k] == 4'h0);
      lz_mask[k] = all_zero;
    end
  end

  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    slot_d       = slot_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    act_d        = act_q;
    frame_done_d = wrap;
    seg_d        = SEG_BLANK;
    an_d         = AN_OFF;

    if (tick) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 3'd1;
    end

    // Swap at the frame boundary first so a coincident load lands in pending
    // for the following frame.
    if (wrap && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d[0]    = d1;
      pend_d[1]    = d2;
      pend_d[2]    = d3;
      pend_d[3]    = d4;
      pend_d[4]    = d5;
      pend_d[5]    = d6;
      pend_valid_d = 1'b1;
    end

    if (div_cnt_q >= BLANK_END) begin
      an_d  = ~(6'b100000 >> slot_q);
      seg_d = (LZ_BLANK && lz_mask[slot_q]) ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      slot_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '{default: '0};
      act_q        <= '{default: '0};
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      slot_q       <= slot_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign dp         = 1'b1;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: directed frame tables, multi-cycle corner
// sequences, and randomized traffic against a frame-time reference model.
module tb_seg_display_scanner;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = 6 * SD;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [5:0] AN_EXP [6] = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset, load;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic [6:0] seg_lz, seg_nl;
  logic [5:0] an_lz, an_nl;
  logic       dp_lz, dp_nl, fd_lz, fd_nl;

  always #5 clk = ~clk;

  seg_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .reset(reset), .load(load),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .seg(seg_lz), .dp(dp_lz), .an(an_lz), .frame_done(fd_lz)
  );

  seg_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b0)) dut_nl (
    .clk(clk), .reset(reset), .load(load),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .seg(seg_nl), .dp(dp_nl), .an(an_nl), .frame_done(fd_nl)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [6:0] exp_q [$];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Display position derives from m_t, the cycle count since reset release.
  int         m_t = 0;
  logic [3:0] m_pend [6];
  logic [3:0] m_act  [6];
  bit         m_pv;
  bit         model_ok = 1'b0;
  logic [6:0] e_seg, e_seg_nl;
  logic [5:0] e_an;
  logic       e_fd;
  int         ph, sl;
  bit         lead;

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_pv = 1'b0;
      for (int j = 0; j < 6; j++) begin m_pend[j] = 4'h0; m_act[j] = 4'h0; end
      e_seg = 7'h7F; e_seg_nl = 7'h7F; e_an = 6'h3F; e_fd = 1'b0;
      model_ok = 1'b1;
    end else begin
      ph = m_t % SD;
      sl = (m_t / SD) % 6;
      if (ph < BL) begin
        e_an = 6'h3F; e_seg = 7'h7F; e_seg_nl = 7'h7F;
      end else begin
        lead = 1'b1;
        for (int j = 0; j <= sl; j++) if (m_act[j] != 4'h0) lead = 1'b0;
        e_an     = AN_EXP[sl];
        e_seg_nl = HEX_TAB[m_act[sl]];
        e_seg    = (sl < 5 && lead) ? 7'h7F : HEX_TAB[m_act[sl]];
      end
      e_fd = ((m_t % FRAME) == FRAME - 1);
      if (e_fd && m_pv) begin
        for (int j = 0; j < 6; j++) m_act[j] = m_pend[j];
        m_pv = 1'b0;
      end
      if (load) begin
        m_pend[0] = d1; m_pend[1] = d2; m_pend[2] = d3;
        m_pend[3] = d4; m_pend[4] = d5; m_pend[5] = d6;
        m_pv = 1'b1;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_seg_lz",  seg_lz, e_seg);
      check("model_seg_nl",  seg_nl, e_seg_nl);
      check("model_an_lz",   {1'b0, an_lz}, {1'b0, e_an});
      check("model_an_nl",   {1'b0, an_nl}, {1'b0, e_an});
      check("model_fd_lz",   {6'b0, fd_lz}, {6'b0, e_fd});
      check("model_fd_nl",   {6'b0, fd_nl}, {6'b0, e_fd});
      check("model_dp",      {5'b0, dp_lz, dp_nl}, 7'b11);
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the negedge where the next rising edge processes model time target.
  task automatic wait_model_t(input int target);
    int n = 0;
    while (m_t != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_t != target) begin
      failures++;
      $display("FAIL wait_timeout: got t=%0d expected t=%0d", m_t, target);
    end
  endtask

  task automatic set_digits(input logic [23:0] v);
    {d1, d2, d3, d4, d5, d6} = v;
  endtask

  task automatic load_at(input int t_edge, input logic [23:0] v);
    wait_model_t(t_edge);
    load = 1'b1;
    set_digits(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [23:0] digs;
    logic [6:0]  seg_lz [6];
    logic [6:0]  seg_nl [6];
  } vec_t;

  vec_t tbl [5];

  initial begin
    int         f;
    logic [6:0] prev_s4;

    tbl[0] = '{24'h003003, '{7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40, 7'h30},
                           '{7'h40, 7'h40, 7'h30, 7'h40, 7'h40, 7'h30}};
    tbl[1] = '{24'h123456, '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02},
                           '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
    tbl[2] = '{24'h000000, '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                           '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[3] = '{24'hABCDEF, '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                           '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
    tbl[4] = '{24'h080907, '{7'h7F, 7'h00, 7'h40, 7'h10, 7'h40, 7'h78},
                           '{7'h40, 7'h00, 7'h40, 7'h10, 7'h40, 7'h78}};

    reset = 1'b1; load = 1'b0; set_digits(24'h0);

    // Reset held for three edges.
    repeat (3) begin
      @(negedge clk);
      check("reset_an",  {1'b0, an_lz}, 7'h3F);
      check("reset_seg", seg_lz, 7'h7F);
      check("reset_fd",  {6'b0, fd_lz}, 7'h0);
    end
    reset = 1'b0;

    // Slot timing after release: blank cycle, then 3 lit cycles per slot.
    wait_model_t(1); check("t0_blank_an", {1'b0, an_lz}, 7'h3F);
    wait_model_t(2); check("t1_slot0_an", {1'b0, an_lz}, 7'h1F);
    wait_model_t(4); check("t3_slot0_an", {1'b0, an_lz}, 7'h1F);
    wait_model_t(5); check("t4_blank_an", {1'b0, an_lz}, 7'h3F);
    wait_model_t(6); check("t5_slot1_an", {1'b0, an_lz}, 7'h2F);

    // Table: load mid-frame, old data persists, new data in next frame.
    prev_s4 = 7'h7F;
    for (int i = 0; i < 5; i++) begin
      f = m_t / FRAME + 1;
      load_at(f * FRAME + 10, tbl[i].digs);
      wait_model_t(f * FRAME + 4 * SD + 3);
      check("old_frame_slot4", seg_lz, prev_s4);
      wait_model_t((f + 1) * FRAME);
      check("frame_done_pulse", {6'b0, fd_lz}, 7'h1);
      for (int k = 0; k < 6; k++) exp_q.push_back(tbl[i].seg_lz[k]);
      for (int k = 0; k < 6; k++) begin
        wait_model_t((f + 1) * FRAME + k * SD + 3);
        check("tbl_seg_lz", seg_lz, exp_q.pop_front());
        check("tbl_seg_nl", seg_nl, tbl[i].seg_nl[k]);
        check("tbl_an", {1'b0, an_lz}, {1'b0, AN_EXP[k]});
      end
      prev_s4 = tbl[i].seg_lz[4];
    end

    // Two loads in one frame: last one wins.
    f = m_t / FRAME + 1;
    load_at(f * FRAME + 5, 24'hABCDEF);
    load_at(f * FRAME + 12, 24'h987654);
    for (int k = 0; k < 6; k++) begin
      wait_model_t((f + 1) * FRAME + k * SD + 2);
      check("last_load_wins", seg_lz, HEX_TAB[9 - k]);
    end

    // Load coincident with the wrap tick.
    f = m_t / FRAME + 1;
    load_at(f * FRAME + 8, 24'h123456);
    load_at(f * FRAME + FRAME - 1, 24'h500002);
    wait_model_t((f + 1) * FRAME + 3);
    check("wrap_load_old", seg_lz, 7'h79);
    wait_model_t((f + 2) * FRAME + 3);
    check("wrap_load_new_s0", seg_lz, 7'h12);
    wait_model_t((f + 2) * FRAME + 5 * SD + 3);
    check("wrap_load_new_s5", seg_lz, 7'h24);

    // Reset mid-slot with pending data; a load in the reset cycle is ignored.
    f = m_t / FRAME + 1;
    load_at(f * FRAME + 3, 24'h222222);
    wait_model_t(f * FRAME + 14);
    reset = 1'b1; load = 1'b1; set_digits(24'h888888);
    @(negedge clk);
    check("midreset_an",  {1'b0, an_lz}, 7'h3F);
    check("midreset_seg", seg_lz, 7'h7F);
    reset = 1'b0; load = 1'b0;
    wait_model_t(2);
    check("post_reset_slot0_an",  {1'b0, an_lz}, 7'h1F);
    check("post_reset_slot0_seg", seg_lz, 7'h7F);
    wait_model_t(FRAME + 5 * SD + 3);
    check("pending_lost_s5", seg_lz, 7'h40);
    check("pending_lost_nl", seg_nl, 7'h40);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      load  = ($urandom_range(0, 9) == 0);
      d1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      d2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      d3 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      d4 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      d5 = 4'($urandom_range(0, 15));
      d6 = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
